// File: rtl/hrd_move_ctrl.sv
// hrd_move_ctrl: 3x3 sliding-tile puzzle controller.
// Holds the board, applies one move per direction pulse, counts legal moves
// and detects the solved layout 1..8 followed by the blank.
module hrd_move_ctrl #(
  parameter logic [9:0] MAX_MOVES = 10'd999
) (
  input  logic       I_clk,
  input  logic       I_rst_n,
  input  logic       I_load,
  input  logic [1:0] I_layout,
  output logic [1:0] O_layout_sel,
  input  logic [3:0] I_tile1,
  input  logic [3:0] I_tile2,
  input  logic [3:0] I_tile3,
  input  logic [3:0] I_tile4,
  input  logic [3:0] I_tile5,
  input  logic [3:0] I_tile6,
  input  logic [3:0] I_tile7,
  input  logic [3:0] I_tile8,
  input  logic [3:0] I_tile9,
  input  logic       I_up,
  input  logic       I_down,
  input  logic       I_left,
  input  logic       I_right,
  output logic [3:0] O_cell1,
  output logic [3:0] O_cell2,
  output logic [3:0] O_cell3,
  output logic [3:0] O_cell4,
  output logic [3:0] O_cell5,
  output logic [3:0] O_cell6,
  output logic [3:0] O_cell7,
  output logic [3:0] O_cell8,
  output logic [3:0] O_cell9,
  output logic [3:0] O_blank_pos,
  output logic [9:0] O_moves,
  output logic       O_busy,
  output logic       O_solved,
  output logic       O_illegal,
  output logic       O_err
);

  localparam int NCELL = 9;

  typedef enum logic [2:0] {IDLE, LOAD, PLAY, MOVE, CHECK, WIN} state_t;
  // Direction is named after the tile that moves, not after the blank.
  typedef enum logic [1:0] {D_UP, D_DOWN, D_LEFT, D_RIGHT} dir_t;

  // board[0] is cell 1 (top-left), row-major.
  localparam logic [NCELL-1:0][3:0] SOLVED =
    {4'd0, 4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1};

  state_t st, nxt;
  dir_t   dir, dir_sel;

  logic [NCELL-1:0][3:0] board, tile_in;
  logic [3:0] blank_pos, first_zero, src_pos, moved_tile;
  logic [9:0] moves;
  logic [3:0] pulses;
  logic       has_zero, legal, one_pulse;
  logic       solved, illegal, err;
  logic       capture, take_move, flag_illegal, do_swap, win_now;

  assign tile_in = {I_tile9, I_tile8, I_tile7, I_tile6, I_tile5,
                    I_tile4, I_tile3, I_tile2, I_tile1};
  assign pulses    = {I_right, I_left, I_down, I_up};
  assign one_pulse = $onehot(pulses);

  // Lowest-index blank in the incoming layout; 0 when the layout has none.
  always_comb begin
    first_zero = 4'd0;
    has_zero   = 1'b0;
    for (int i = NCELL - 1; i >= 0; i--) begin
      if (tile_in[i] == 4'd0) begin
        first_zero = 4'(i + 1);
        has_zero   = 1'b1;
      end
    end
  end

  // Decode a single pulse and check the blank has a source tile on that side.
  always_comb begin
    dir_sel = D_UP;
    legal   = 1'b0;
    case (pulses)
      4'b0001: begin
        dir_sel = D_UP;
        legal   = (blank_pos < 4'd7);
      end
      4'b0010: begin
        dir_sel = D_DOWN;
        legal   = (blank_pos > 4'd3);
      end
      4'b0100: begin
        dir_sel = D_LEFT;
        legal   = !(blank_pos == 4'd3 || blank_pos == 4'd6 || blank_pos == 4'd9);
      end
      4'b1000: begin
        dir_sel = D_RIGHT;
        legal   = !(blank_pos == 4'd1 || blank_pos == 4'd4 || blank_pos == 4'd7);
      end
      default: ;
    endcase
  end

  // Source cell of the latched move and the tile that slides into the blank.
  always_comb begin
    case (dir)
      D_UP:    src_pos = blank_pos + 4'd3;
      D_DOWN:  src_pos = blank_pos - 4'd3;
      D_LEFT:  src_pos = blank_pos + 4'd1;
      default: src_pos = blank_pos - 4'd1;
    endcase
    moved_tile = 4'd0;
    for (int i = 0; i < NCELL; i++)
      if (src_pos == 4'(i + 1)) moved_tile = board[i];
  end

  // Load overrides everything, including a move already latched.
  assign capture      = (st == LOAD);
  assign take_move    = (st == PLAY) && !I_load && one_pulse && legal;
  assign flag_illegal = (st == PLAY) && !I_load && one_pulse && !legal;
  assign do_swap      = (st == MOVE) && !I_load;
  assign win_now      = (st == CHECK) && !I_load && (board == SOLVED);

  // State register.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) st <= IDLE;
    else          st <= nxt;
  end

  // Next-state logic.
  always_comb begin
    nxt = st;
    case (st)
      IDLE:    nxt = IDLE;
      LOAD:    nxt = has_zero ? PLAY : IDLE;
      PLAY:    if (take_move) nxt = MOVE;
      MOVE:    nxt = CHECK;
      CHECK:   nxt = win_now ? WIN : PLAY;
      WIN:     nxt = WIN;
      default: nxt = IDLE;
    endcase
    if (I_load) nxt = LOAD;
  end

  // Board storage: whole-layout capture or a single blank/source swap.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      board <= '0;
    end else if (capture) begin
      board <= tile_in;
    end else if (do_swap) begin
      for (int i = 0; i < NCELL; i++) begin
        if (blank_pos == 4'(i + 1))    board[i] <= moved_tile;
        else if (src_pos == 4'(i + 1)) board[i] <= 4'd0;
      end
    end
  end

  // Blank tracking, move counter and status flags.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      dir       <= D_UP;
      blank_pos <= 4'd0;
      moves     <= 10'd0;
      solved    <= 1'b0;
      illegal   <= 1'b0;
      err       <= 1'b0;
    end else begin
      illegal <= flag_illegal;
      if (take_move) dir <= dir_sel;
      if (capture) begin
        blank_pos <= first_zero;
        moves     <= 10'd0;
        solved    <= 1'b0;
        err       <= !has_zero;
      end else if (do_swap) begin
        blank_pos <= src_pos;
        if (moves < MAX_MOVES) moves <= moves + 10'd1;
      end
      if (win_now) solved <= 1'b1;
    end
  end

  assign O_layout_sel = I_layout;
  assign {O_cell9, O_cell8, O_cell7, O_cell6, O_cell5,
          O_cell4, O_cell3, O_cell2, O_cell1} = board;
  assign O_blank_pos = blank_pos;
  assign O_moves     = moves;
  assign O_busy      = (st == LOAD) || (st == MOVE) || (st == CHECK);
  assign O_solved    = solved;
  assign O_illegal   = illegal;
  assign O_err       = err;

endmodule
